// File: rtl/hh_rate_div.sv
// hh_rate_div: gating rate = num / (exp_in - BIAS), signed Q10.12, sequential restoring divider
// Ports: clk; rst (async, active low); num/exp_in sampled with exp_valid;
//        rate_out/sat/sing valid with the rate_valid pulse; busy while dividing;
//        overrun pulses when exp_valid arrives while busy (input dropped).
module hh_rate_div #(
  parameter int DW       = 22,
  parameter int FW       = 12,
  parameter int BIAS     = 4096,
  parameter int EPS      = 0,
  parameter int SING_VAL = 410
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] num,
  input  logic [DW-1:0] exp_in,
  input  logic          exp_valid,
  output logic [DW-1:0] rate_out,
  output logic          rate_valid,
  output logic          busy,
  output logic          sat,
  output logic          sing,
  output logic          overrun
);
  localparam int QW = DW + FW;
  localparam int RW = DW + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic [DW:0]   BIAS_X = (DW+1)'(BIAS);
  localparam logic [DW:0]   EPS_X  = (DW+1)'(EPS);
  localparam logic [QW-1:0] POS_LIM = QW'((2**(DW-1)) - 1);
  localparam logic [QW-1:0] NEG_LIM = QW'(2**(DW-1));
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t        state_q, state_d;
  logic          sign_q, sign_d, spath_q, spath_d;
  logic [QW-1:0] dvd_q, dvd_d, quo_q, quo_d;
  logic [DW:0]   dvs_q, dvs_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rate_out_q, rate_out_d;
  logic          rate_valid_q, rate_valid_d, busy_q, busy_d, sat_q, sat_d;
  logic          sing_q, sing_d, overrun_q, overrun_d;
  logic [DW:0]   den, abs_den;
  logic [DW-1:0] abs_num;
  logic [RW:0]   sh, diff;
  logic          singular, ge, pos_ovf, neg_ovf;
  always_comb begin
    den      = {exp_in[DW-1], exp_in} - BIAS_X;
    abs_den  = den[DW] ? -den : den;
    abs_num  = num[DW-1] ? -num : num;
    singular = abs_den <= EPS_X;
    // remainder stays below the divisor, so the shifted value never reaches bit RW;
    // a set top bit of the difference therefore means the trial subtract borrowed
    sh       = {rem_q, dvd_q[QW-1]};
    diff     = sh - (RW+1)'(dvs_q);
    ge       = !diff[RW];
    pos_ovf  = !sign_q && (quo_q > POS_LIM);
    neg_ovf  = sign_q && (quo_q > NEG_LIM);
    state_d      = state_q;
    sign_d       = sign_q;
    spath_d      = spath_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    rate_out_d   = rate_out_q;
    rate_valid_d = 1'b0;
    busy_d       = busy_q;
    sat_d        = sat_q;
    sing_d       = sing_q;
    overrun_d    = exp_valid && busy_q;
    case (state_q)
      IDLE: if (exp_valid) begin
        sign_d  = num[DW-1] ^ den[DW];
        spath_d = singular;
        dvd_d   = {abs_num, {FW{1'b0}}};
        dvs_d   = abs_den;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = singular ? DONE : DIV;
      end
      DIV: begin
        rem_d   = ge ? diff[RW-1:0] : sh[RW-1:0];
        quo_d   = {quo_q[QW-2:0], ge};
        dvd_d   = {dvd_q[QW-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(QW - 1)) ? DONE : DIV;
      end
      DONE: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        rate_valid_d = 1'b1;
        sing_d       = spath_q;
        sat_d        = !spath_q && (pos_ovf || neg_ovf);
        rate_out_d   = spath_q ? DW'(SING_VAL) :
                       pos_ovf ? POS_LIM[DW-1:0] :
                       neg_ovf ? NEG_LIM[DW-1:0] :
                       sign_q  ? -quo_q[DW-1:0] : quo_q[DW-1:0];
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      spath_q      <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      sat_q        <= 1'b0;
      sing_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      spath_q      <= spath_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      busy_q       <= busy_d;
      sat_q        <= sat_d;
      sing_q       <= sing_d;
      overrun_q    <= overrun_d;
    end
  end
  assign rate_out   = rate_out_q;
  assign rate_valid = rate_valid_q;
  assign busy       = busy_q;
  assign sat        = sat_q;
  assign sing       = sing_q;
  assign overrun    = overrun_q;
endmodule

// File: doc/hh_rate_div.md
Name: hh_rate_div

Overview:
- Downstream stage of the fixed-point exponential unit in the HH neuron processing element.
- Consumes each exponential result (with its done strobe) and a numerator term. Produces the gating rate `rate = num / (exp_in - BIAS)`, the form used by the alpha_n/alpha_m rate functions.
- Sequential restoring divider in signed Q10.12, 22-bit data.
- Replaces a near-zero denominator with a programmed limit value (the 0/0 singularity of the rate functions).

Parameters:
- DW, 22, total data width (signed, two's complement).
- FW, 12, fractional bits (Q10.12).
- BIAS, 4096, value subtracted from exp_in to form the denominator (1.0 in Q10.12).
- EPS, 0, singular threshold; the denominator is singular when |den| <= EPS.
- SING_VAL, 410, Q10.12 result substituted at the singularity (about 0.1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- num  in  DW  signed Q10.12 numerator, sampled with exp_valid.
- exp_in  in  DW  signed Q10.12 exponential result, sampled with exp_valid.
- exp_valid  in  1  one-cycle strobe from the exponential stage's done output.
- rate_out  out  DW  signed Q10.12 quotient, held until the next result.
- rate_valid  out  1  one-cycle pulse, rate_out valid.
- busy  out  1  high while a division is in progress.
- sat  out  1  rate_out was saturated; valid with rate_valid.
- sing  out  1  singular path taken; valid with rate_valid.
- overrun  out  1  one-cycle pulse when exp_valid arrives while busy (input dropped).

Behaviour:
- Reset (rst=0, async): state=IDLE. rate_out, rate_valid, busy, sat, sing and overrun are all 0. Internal registers are cleared. Reset mid-division aborts the operation with no rate_valid.
- States:
  - IDLE -> DIV on an exp_valid edge with non-singular den.
  - IDLE -> DONE on an exp_valid edge with singular den.
  - DIV -> DONE after ITER = DW+FW = 34 iteration edges.
  - DONE -> IDLE after one edge.
- Accept edge (IDLE, exp_valid=1):
  - Latch the quotient sign: `sign(num) XOR sign(den)`.
  - `den = exp_in - BIAS`, computed at DW+1 bits with no overflow.
  - `dividend = |num| << FW` (34-bit unsigned; |-2^21| = 2^21 is representable).
  - `divisor = |den|` (23-bit unsigned).
  - busy=1 from this edge.
- DIV: one restoring step per cycle, MSB first. Remainder is DW+2 bits. Quotient is 34-bit unsigned, truncated toward zero.
- DONE (outputs registered on the edge leaving DONE; rate_valid high for exactly one cycle):
  - Singular: rate_out=SING_VAL, sing=1, sat=0.
  - Otherwise, positive result with quotient > 2^21-1: rate_out=2^21-1, sat=1.
  - Otherwise, negative result with quotient > 2^21: rate_out=-2^21, sat=1.
  - Otherwise, rate_out = sign ? -q : q. A zero quotient gives rate_out=0.
- Latency from the accept edge to the rate_valid-high edge:
  - Normal: ITER+1 = 35 edges.
  - Singular: 1 edge.
- busy timing: busy drops on the same edge rate_valid rises. A new exp_valid in that cycle is accepted (back-to-back operation).
- exp_valid while busy=1: the input is ignored, overrun pulses on the next edge, and the in-flight operation is unaffected.
- sat and sing are updated only on rate_valid edges and hold otherwise. rate_out also holds between results.
- Inputs are sampled only on the accept edge; changes to num/exp_in during DIV have no effect.

Test Plan:
- num=4096, exp_in=12288 (den=2.0) -> rate_out=2048, rate_valid exactly 35 edges after accept, sat=0, sing=0.
- num=-4096, exp_in=2048 (den=-0.5) -> rate_out=8192. Then num=4096, exp_in=16384 -> rate_out=1365 (truncation check).
- num=1234, exp_in=4096 (den=0, EPS=0) -> rate_out=410, sing=1, rate_valid 1 edge after accept.
- num=2097151, exp_in=4097 (den=1) -> rate_out=2097151, sat=1. num=-2097152, exp_in=4097 -> rate_out=-2097152, sat=1.
- Second exp_valid 10 cycles after the first accept -> overrun pulse, first result unaffected, no second rate_valid. A strobe in the rate_valid cycle -> accepted, next result 35 edges later.
- rst low 10 cycles into DIV -> all outputs 0 immediately, no rate_valid. After release, num=4096, exp_in=12288 -> rate_out=2048.
